// File: rtl/jk_excite_counter.sv
// Modulo-MODULUS up/down counter whose state register is updated through
// per-bit JK excitation, exposed so an external JK flip-flop bank can follow.
module jk_excite_counter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             tc,
    output logic             load_err
);

    // One extra bit so MODULUS == 2^WIDTH is representable in comparisons.
    localparam int unsigned EXT_W = WIDTH + 1;
    localparam logic [EXT_W-1:0] MOD_EXT = EXT_W'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] ns;
    logic             wrap;
    logic             load_bad;

    // Next-state selection: reset > load > count > hold.
    always_comb begin
        ns       = q;
        wrap     = 1'b0;
        load_bad = 1'b0;
        if (reset) begin
            ns = '0;
        end else if (load) begin
            if ({1'b0, load_val} < MOD_EXT) begin
                ns = load_val;
            end else begin
                ns       = '0;
                load_bad = 1'b1;
            end
        end else if (en) begin
            if (up) begin
                if (q == MAX_VAL) begin
                    ns   = '0;
                    wrap = 1'b1;
                end else if ({1'b0, q} >= MOD_EXT) begin
                    ns = '0;
                end else begin
                    ns = q + WIDTH'(1);
                end
            end else begin
                if (q == '0) begin
                    ns   = MAX_VAL;
                    wrap = 1'b1;
                end else begin
                    ns = q - WIDTH'(1);
                end
            end
        end
    end

    // Minimal JK excitation; during reset this gives j=0, k=q.
    always_comb begin
        j_out = ~q & ns;
        k_out = q & ~ns;
    end

    // State advances through the JK characteristic equation; flags are one-cycle pulses.
    always_ff @(posedge clk) begin
        q <= (j_out & ~q) | (~k_out & q);
        if (reset) begin
            tc       <= 1'b0;
            load_err <= 1'b0;
        end else begin
            tc       <= wrap;
            load_err <= load_bad;
        end
    end

endmodule
